// File: rtl/ccd_seq_pkg.sv
// Shared constants and state type for the CCD readout sequencer and its pixel timer.
package ccd_seq_pkg;

  localparam int DEF_CNT_W  = 4;
  localparam int DEF_PIX_W  = 10;
  localparam int DEF_INT_W  = 16;
  localparam int MIN_PERIOD = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INTEG = 2'd1,
    ST_READ  = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

endpackage

// File: rtl/ccd_pixel_timer.sv
// Pixel phase counter: runs 0..max_i and strobes sample_o in the cycle where the phase equals max_i.
module ccd_pixel_timer
  import ccd_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [CNT_W-1:0] max_i,
  output logic             sample_o
);

  logic [CNT_W-1:0] ph_q, ph_d;
  logic             sample_q, sample_d;

  // The strobe is registered from the next phase so it lines up with the phase it marks.
  always_comb begin
    ph_d     = ph_q;
    sample_d = 1'b0;
    if (clr_i) begin
      ph_d = '0;
    end else if (en_i) begin
      ph_d     = (ph_q == max_i) ? '0 : ph_q + CNT_W'(1);
      sample_d = (ph_d == max_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ph_q     <= '0;
      sample_q <= 1'b0;
    end else begin
      ph_q     <= ph_d;
      sample_q <= sample_d;
    end
  end

  assign sample_o = sample_q;

endmodule

// File: rtl/ccd_readout_sequencer.sv
// Frame controller: integration window, then n_pix pixel periods of phase-generator readout.
module ccd_readout_sequencer
  import ccd_seq_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W,
  parameter int PIX_W = DEF_PIX_W,
  parameter int INT_W = DEF_INT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [INT_W-1:0] int_time_i,
  input  logic [PIX_W-1:0] n_pix_i,
  input  logic [CNT_W-1:0] period_i,
  output logic             busy_o,
  output logic             shutter_o,
  output logic             gen_en_o,
  output logic [CNT_W-1:0] max_val_o,
  output logic             sample_o,
  output logic [PIX_W-1:0] pix_idx_o,
  output logic             frame_done_o
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] INTEG = ST_INTEG;
  localparam logic [1:0] READ  = ST_READ;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]       state_q, state_d;
  logic [INT_W-1:0] int_cnt_q, int_cnt_d;
  logic [PIX_W-1:0] n_pix_q, n_pix_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CNT_W-1:0] max_val_q, max_val_d;
  logic             busy_q, shutter_q, gen_en_q, done_q;
  logic [CNT_W-1:0] per_l;
  logic             sample_w;

  assign per_l = (period_i == '0) ? CNT_W'(MIN_PERIOD) : period_i;

  always_comb begin
    state_d   = state_q;
    int_cnt_d = int_cnt_q;
    n_pix_d   = n_pix_q;
    pix_d     = pix_q;
    max_val_d = max_val_q;
    case (state_q)
      IDLE: begin
        if (start_i && !abort_i) begin
          n_pix_d   = n_pix_i;
          max_val_d = per_l;
          int_cnt_d = int_time_i;
          pix_d     = '0;
          if (n_pix_i == '0)         state_d = DONE;
          else if (int_time_i == '0) state_d = READ;
          else                       state_d = INTEG;
        end
      end
      INTEG: begin
        int_cnt_d = int_cnt_q - INT_W'(1);
        if (int_cnt_q <= INT_W'(1)) state_d = READ;
      end
      READ: begin
        if (sample_w) begin
          if (pix_q == n_pix_q - PIX_W'(1)) state_d = DONE;
          else                              pix_d   = pix_q + PIX_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        pix_d   = '0;
      end
    endcase
    // Abort drops straight to IDLE but keeps the latched period on max_val.
    if (abort_i && state_q != IDLE) begin
      state_d = IDLE;
      pix_d   = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      int_cnt_q <= '0;
      n_pix_q   <= '0;
      pix_q     <= '0;
      max_val_q <= '0;
      busy_q    <= 1'b0;
      shutter_q <= 1'b0;
      gen_en_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      int_cnt_q <= int_cnt_d;
      n_pix_q   <= n_pix_d;
      pix_q     <= pix_d;
      max_val_q <= max_val_d;
      busy_q    <= (state_d != IDLE);
      shutter_q <= (state_d == INTEG);
      gen_en_q  <= (state_d == READ);
      done_q    <= (state_d == DONE);
    end
  end

  // Phase is held at zero outside READ, so entering READ needs no explicit clear.
  ccd_pixel_timer #(.CNT_W(CNT_W)) u_timer (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .en_i     (state_q == READ),
    .clr_i    (state_d != READ),
    .max_i    (max_val_q),
    .sample_o (sample_w)
  );

  assign busy_o       = busy_q;
  assign shutter_o    = shutter_q;
  assign gen_en_o     = gen_en_q;
  assign max_val_o    = max_val_q;
  assign sample_o     = sample_w;
  assign pix_idx_o    = pix_q;
  assign frame_done_o = done_q;

endmodule

// File: tb/tb_ccd_readout_sequencer.sv
// Bench for ccd_readout_sequencer: frame-timeline model checked every cycle plus hand-computed frame totals.
module tb_ccd_readout_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, abort;
  logic [15:0] intTime;
  logic [9:0]  nPix;
  logic [3:0]  period;
  logic        busy, shutter, genEn, sample, frameDone;
  logic [3:0]  maxVal;
  logic [9:0]  pixIdx;

  int checks = 0;
  int passes = 0;
  bit checkEn = 1'b0;

  always #5 clk = ~clk;

  ccd_readout_sequencer #(.CNT_W(4), .PIX_W(10), .INT_W(16)) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .abort_i      (abort),
    .int_time_i   (intTime),
    .n_pix_i      (nPix),
    .period_i     (period),
    .busy_o       (busy),
    .shutter_o    (shutter),
    .gen_en_o     (genEn),
    .max_val_o    (maxVal),
    .sample_o     (sample),
    .pix_idx_o    (pixIdx),
    .frame_done_o (frameDone)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
  endtask

  // Model: a frame is a timeline of offsets k from the accepting edge.
  bit mActive = 1'b0;
  int mK = 0, mI = 0, mN = 0, mP = 1, mMax = 0;

  function automatic int lastOffset();
    return (mN == 0) ? 0 : mI + mN * (mP + 1);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mActive = 1'b0;
      mMax    = 0;
    end else if (mActive) begin
      if (abort || mK == lastOffset()) mActive = 1'b0;
      else mK++;
    end else if (start && !abort) begin
      mActive = 1'b1;
      mK      = 0;
      mI      = int'(intTime);
      mN      = int'(nPix);
      mP      = (period == 4'd0) ? 1 : int'(period);
      mMax    = mP;
    end
  end

  always @(negedge clk) begin
    int eBusy, eShut, eGen, eSamp, ePix, eDone, r;
    eBusy = 0; eShut = 0; eGen = 0; eSamp = 0; ePix = 0; eDone = 0;
    if (mActive) begin
      eBusy = 1;
      if (mN == 0) eDone = 1;
      else if (mK < mI) eShut = 1;
      else if (mK < lastOffset()) begin
        r     = mK - mI;
        eGen  = 1;
        eSamp = ((r % (mP + 1)) == mP) ? 1 : 0;
        ePix  = r / (mP + 1);
      end else begin
        eDone = 1;
        ePix  = mN - 1;
      end
    end
    if (checkEn) begin
      checkOutput("busy", 32'(busy), 32'(eBusy));
      checkOutput("shutter", 32'(shutter), 32'(eShut));
      checkOutput("gen_en", 32'(genEn), 32'(eGen));
      checkOutput("sample", 32'(sample), 32'(eSamp));
      checkOutput("pix_idx", 32'(pixIdx), 32'(ePix));
      checkOutput("frame_done", 32'(frameDone), 32'(eDone));
      checkOutput("max_val", 32'(maxVal), 32'(mMax));
    end
  end

  // Per-frame totals of what the DUT actually produced.
  int busyCnt, shutCnt, genCnt, doneCnt, genIdx, maxPix;
  int sampPos[$];

  always @(negedge clk) begin
    if (checkEn) begin
      if (busy === 1'b1) busyCnt++;
      if (shutter === 1'b1) shutCnt++;
      if (frameDone === 1'b1) doneCnt++;
      if (genEn === 1'b1) begin
        genCnt++;
        genIdx++;
      end
      if (sample === 1'b1) sampPos.push_back(genIdx);
      if (int'(pixIdx) > maxPix) maxPix = int'(pixIdx);
    end
  end

  task automatic clearMon();
    busyCnt = 0; shutCnt = 0; genCnt = 0; doneCnt = 0; genIdx = 0; maxPix = 0;
    sampPos.delete();
  endtask

  function automatic int sampAt(input int i);
    return (i < sampPos.size()) ? sampPos[i] : -1;
  endfunction

  task automatic applyStimulus(input logic r, input logic s, input logic a,
                               input logic [15:0] it, input logic [9:0] np, input logic [3:0] per);
    rst = r; start = s; abort = a;
    intTime = it; nPix = np; period = per;
    @(negedge clk);
    rst = 1'b0; start = 1'b0; abort = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic waitIdle(input int bound);
    int c = 0;
    while (busy === 1'b1 && c < bound) begin
      @(negedge clk);
      c++;
    end
    if (c >= bound) checkOutput("wait_idle_timeout", 32'(c), 32'(0));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    intTime = '0; nPix = '0; period = '0;
    @(negedge clk);
    checkEn = 1'b1;
    applyStimulus(1, 0, 0, 0, 0, 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_max_val", 32'(maxVal), 0);
    checkOutput("reset_pix_idx", 32'(pixIdx), 0);
    idleCycles(2);

    $display("[TB] frame int_time=5 n_pix=3 period=3");
    clearMon();
    applyStimulus(0, 1, 0, 16'd5, 10'd3, 4'd3);
    waitIdle(40);
    checkOutput("f1_shutter_cycles", 32'(shutCnt), 5);
    checkOutput("f1_gen_cycles", 32'(genCnt), 12);
    checkOutput("f1_sample_count", 32'(sampPos.size()), 3);
    checkOutput("f1_sample0", 32'(sampAt(0)), 4);
    checkOutput("f1_sample1", 32'(sampAt(1)), 8);
    checkOutput("f1_sample2", 32'(sampAt(2)), 12);
    checkOutput("f1_max_pix", 32'(maxPix), 2);
    checkOutput("f1_done_count", 32'(doneCnt), 1);
    checkOutput("f1_busy_cycles", 32'(busyCnt), 18);
    checkOutput("f1_max_val", 32'(maxVal), 3);

    $display("[TB] frame int_time=0 n_pix=2 period=0");
    clearMon();
    applyStimulus(0, 1, 0, 16'd0, 10'd2, 4'd0);
    waitIdle(40);
    checkOutput("f2_shutter_cycles", 32'(shutCnt), 0);
    checkOutput("f2_gen_cycles", 32'(genCnt), 4);
    checkOutput("f2_sample0", 32'(sampAt(0)), 2);
    checkOutput("f2_sample1", 32'(sampAt(1)), 4);
    checkOutput("f2_max_val", 32'(maxVal), 1);
    checkOutput("f2_done_count", 32'(doneCnt), 1);
    checkOutput("f2_busy_cycles", 32'(busyCnt), 5);

    $display("[TB] frame n_pix=0 int_time=7");
    clearMon();
    applyStimulus(0, 1, 0, 16'd7, 10'd0, 4'd5);
    waitIdle(10);
    checkOutput("f3_shutter_cycles", 32'(shutCnt), 0);
    checkOutput("f3_gen_cycles", 32'(genCnt), 0);
    checkOutput("f3_busy_cycles", 32'(busyCnt), 1);
    checkOutput("f3_done_count", 32'(doneCnt), 1);

    $display("[TB] start and abort together in idle");
    clearMon();
    applyStimulus(0, 1, 1, 16'd5, 10'd3, 4'd3);
    idleCycles(3);
    checkOutput("sa_busy_cycles", 32'(busyCnt), 0);

    $display("[TB] abort during readout at pix_idx=1");
    clearMon();
    applyStimulus(0, 1, 0, 16'd2, 10'd4, 4'd2);
    begin
      int c = 0;
      while (pixIdx !== 10'd1 && c < 50) begin
        @(negedge clk);
        c++;
      end
      if (c >= 50) checkOutput("abort_wait_timeout", 32'(c), 0);
    end
    applyStimulus(0, 0, 1, 16'd2, 10'd4, 4'd2);
    checkOutput("ab_busy", 32'(busy), 0);
    checkOutput("ab_gen_en", 32'(genEn), 0);
    checkOutput("ab_sample", 32'(sample), 0);
    checkOutput("ab_max_val", 32'(maxVal), 2);
    idleCycles(3);
    checkOutput("ab_done_count", 32'(doneCnt), 0);
    clearMon();
    applyStimulus(0, 1, 0, 16'd2, 10'd4, 4'd2);
    waitIdle(40);
    checkOutput("ab2_gen_cycles", 32'(genCnt), 12);
    checkOutput("ab2_sample_count", 32'(sampPos.size()), 4);
    checkOutput("ab2_busy_cycles", 32'(busyCnt), 15);
    checkOutput("ab2_done_count", 32'(doneCnt), 1);

    $display("[TB] restart ignored mid-frame");
    clearMon();
    applyStimulus(0, 1, 0, 16'd3, 10'd3, 4'd3);
    idleCycles(1);
    applyStimulus(0, 1, 0, 16'd3, 10'd3, 4'd9);
    idleCycles(6);
    applyStimulus(0, 1, 0, 16'd3, 10'd3, 4'd9);
    waitIdle(40);
    checkOutput("rs_max_val", 32'(maxVal), 3);
    checkOutput("rs_sample0", 32'(sampAt(0)), 4);
    checkOutput("rs_sample1", 32'(sampAt(1)), 8);
    checkOutput("rs_sample2", 32'(sampAt(2)), 12);
    checkOutput("rs_busy_cycles", 32'(busyCnt), 16);
    period = 4'd0;

    $display("[TB] reset during integration");
    clearMon();
    applyStimulus(0, 1, 0, 16'd100, 10'd2, 4'd1);
    idleCycles(10);
    applyStimulus(1, 0, 0, 16'd100, 10'd2, 4'd1);
    checkOutput("rr_busy", 32'(busy), 0);
    checkOutput("rr_shutter", 32'(shutter), 0);
    checkOutput("rr_gen_en", 32'(genEn), 0);
    checkOutput("rr_max_val", 32'(maxVal), 0);
    checkOutput("rr_pix_idx", 32'(pixIdx), 0);
    idleCycles(3);
    checkOutput("rr_done_count", 32'(doneCnt), 0);
    checkOutput("rr_shutter_cycles", 32'(shutCnt), 11);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
